// File: rtl/rf_pkg.sv
// Purpose: shared register-file constants for the register file and its write-back arbiter.
// Latency: none (constants only).
// Backpressure: none (constants only).
//
// Contents: XLEN (data width), NREGS (architectural registers), AW (register index width),
// ZERO_REG (hard-wired zero register index).
package rf_pkg;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int AW    = $clog2(NREGS);

    localparam logic [AW-1:0] ZERO_REG = 5'd0;

endpackage

// File: rtl/rf_wb_arbiter_rr.sv
// Purpose: combinational round-robin grant over NREQ valid lines, search starting at ptr.
// Latency: purely combinational, zero cycles.
// Backpressure: none; at most one grant bit is high, and none when no valid bit is set.
//
// Ports:
//   valid    in   NREQ  request lines
//   ptr      in   PW    highest-priority index this cycle (always < NREQ)
//   grant    out  NREQ  one-hot grant (or zero)
//   gnt_idx  out  PW    index of the granted requester (0 when none)
//   gnt_any  out  1     some requester is granted
module rr_arbiter #(
    parameter int NREQ = 2,
    parameter int PW   = 1
) (
    input  logic [NREQ-1:0] valid,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] grant,
    output logic [PW-1:0]   gnt_idx,
    output logic            gnt_any
);

    logic          found;
    logic [PW-1:0] idx_k;

    // Walk the requesters starting at ptr, wrapping modulo NREQ; first valid one wins.
    always_comb begin
        grant   = '0;
        gnt_idx = '0;
        found   = 1'b0;
        idx_k   = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx_k = PW'((int'(ptr) + k) % NREQ);
            if (!found && valid[idx_k]) begin
                grant[idx_k] = 1'b1;
                gnt_idx      = idx_k;
                found        = 1'b1;
            end
        end
    end

    assign gnt_any = found;

endmodule

// File: rtl/rf_wb_arbiter.sv
// Purpose: shares the register-file write port among NREQ write-back requesters; keeps a pending-write scoreboard.
// Latency: 1 cycle from transfer (valid & ready) to RegWrite/Rd/write_data.
// Backpressure: round-robin valid/ready per requester; the output stage never stalls.
//
// Optional macro RF_WB_STATS_EN adds conflict_cnt (cycles with 2+ requesters valid, saturating).
//
// Ports:
//   clk, reset            clock; asynchronous active-low reset
//   req_valid/req_ready   per-requester handshake (NREQ bits each)
//   req_rd / req_data     packed per-requester destination index / write data
//   alloc_valid/alloc_rd  issue stage marks a destination pending
//   RegWrite/Rd/write_data registered register-file write port
//   busy                  per-register outstanding-write scoreboard
//   conflict_cnt          (RF_WB_STATS_EN only) contention counter
module rf_wb_arbiter
    import rf_pkg::*;
#(
    parameter int NREQ = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*AW-1:0]   req_rd,
    input  logic [NREQ*XLEN-1:0] req_data,
    input  logic                 alloc_valid,
    input  logic [AW-1:0]        alloc_rd,
    output logic                 RegWrite,
    output logic [AW-1:0]        Rd,
    output logic [XLEN-1:0]      write_data,
    output logic [NREGS-1:0]     busy
`ifdef RF_WB_STATS_EN
    ,
    output logic [31:0]          conflict_cnt
`endif
);

    localparam int PW = (NREQ > 2) ? $clog2(NREQ) : 1;

    logic [PW-1:0]    rr_ptr;
    logic [NREQ-1:0]  grant;
    logic [PW-1:0]    gnt_idx;
    logic             gnt_any;
    logic             xfer;
    logic [AW-1:0]    wb_rd;
    logic [XLEN-1:0]  wb_data;
    logic [NREGS-1:0] busy_nxt;

    rr_arbiter #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_rr (
        .valid   (req_valid),
        .ptr     (rr_ptr),
        .grant   (grant),
        .gnt_idx (gnt_idx),
        .gnt_any (gnt_any)
    );

    // Ready drops immediately with reset so nothing is accepted during it.
    assign req_ready = grant & {NREQ{reset}};
    assign xfer      = gnt_any & reset;

    always_comb begin
        wb_rd   = '0;
        wb_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                wb_rd   = req_rd[i*AW +: AW];
                wb_data = req_data[i*XLEN +: XLEN];
            end
        end
    end

    // Clear on write-back first, then set on allocate, so a same-cycle
    // allocate to the retiring register keeps the new producer outstanding.
    always_comb begin
        busy_nxt = busy;
        if (xfer) begin
            busy_nxt[wb_rd] = 1'b0;
        end
        if (alloc_valid && alloc_rd != ZERO_REG) begin
            busy_nxt[alloc_rd] = 1'b1;
        end
        busy_nxt[ZERO_REG] = 1'b0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            RegWrite   <= 1'b0;
            Rd         <= '0;
            write_data <= '0;
            busy       <= '0;
            rr_ptr     <= '0;
        end else begin
            // x0 writes are accepted but never reach the register file.
            RegWrite <= xfer && (wb_rd != ZERO_REG);
            busy     <= busy_nxt;
            if (xfer) begin
                Rd         <= wb_rd;
                write_data <= wb_data;
                rr_ptr     <= (gnt_idx == PW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
            end
        end
    end

`ifdef RF_WB_STATS_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            conflict_cnt <= '0;
        end else if ($countones(req_valid) >= 2 && conflict_cnt != 32'hFFFF_FFFF) begin
            conflict_cnt <= conflict_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Purpose: directed self-checking bench for rf_wb_arbiter with NREQ=2.
// Latency: inputs driven 1 time unit after the rising edge; outputs sampled at the falling edge or 1 unit after the rising edge.
// Backpressure: requesters hold valid until granted; protocol monitors flag illegal stimulus.
module tb_rf_wb_arbiter;
    import rf_pkg::*;

    localparam int NREQ = 2;

    logic                 clk;
    logic                 reset;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ*AW-1:0]   req_rd;
    logic [NREQ*XLEN-1:0] req_data;
    logic                 alloc_valid;
    logic [AW-1:0]        alloc_rd;
    logic                 RegWrite;
    logic [AW-1:0]        Rd;
    logic [XLEN-1:0]      write_data;
    logic [NREGS-1:0]     busy;
`ifdef RF_WB_STATS_EN
    logic [31:0]          conflict_cnt;
`endif

    int checks = 0;
    int errors = 0;

    rf_wb_arbiter #(.NREQ(NREQ)) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_rd      (req_rd),
        .req_data    (req_data),
        .alloc_valid (alloc_valid),
        .alloc_rd    (alloc_rd),
        .RegWrite    (RegWrite),
        .Rd          (Rd),
        .write_data  (write_data),
        .busy        (busy)
`ifdef RF_WB_STATS_EN
        ,
        .conflict_cnt(conflict_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Protocol monitors: valid must be held until ready; no allocate of an
    // already-busy register unless it retires in the same cycle.
    logic [NREQ-1:0] prev_pend = '0;
    always @(negedge clk) begin
        logic          wb_hit;
        logic [AW-1:0] a_rd;
        a_rd   = alloc_rd;
        wb_hit = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (req_valid[i] && req_ready[i] && req_rd[i*AW +: AW] == a_rd) wb_hit = 1'b1;
        end
        if (reset) begin
            if ((prev_pend & ~req_valid) != '0)
                $error("protocol violation: valid dropped before ready (%b)", prev_pend & ~req_valid);
            if (alloc_valid && a_rd != ZERO_REG && busy[a_rd] && !wb_hit)
                $error("protocol violation: allocate of busy register %0d", a_rd);
            prev_pend = req_valid & ~req_ready;
        end else begin
            prev_pend = '0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset       = 1'b0;
        req_valid   = 2'b01;
        req_rd      = '0;
        req_data    = '0;
        alloc_valid = 1'b0;
        alloc_rd    = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (req_ready !== 2'b00) begin
            errors++; $display("FAIL reset_ready got %b exp 00", req_ready);
        end
        req_valid = 2'b00;
        reset     = 1'b1;
        @(negedge clk);
        checks++;
        if (RegWrite !== 1'b0) begin
            errors++; $display("FAIL reset_regwrite got %b exp 0", RegWrite);
        end
        checks++;
        if (busy !== 32'h0) begin
            errors++; $display("FAIL reset_busy got %h exp 0", busy);
        end
        checks++;
        if (Rd !== 5'd0 || write_data !== 32'h0) begin
            errors++; $display("FAIL reset_rd_data got %0d/%h exp 0/0", Rd, write_data);
        end
        checks++;
        if (req_ready !== 2'b00) begin
            errors++; $display("FAIL idle_ready got %b exp 00", req_ready);
        end
`ifdef RF_WB_STATS_EN
        checks++;
        if (conflict_cnt !== 32'd0) begin
            errors++; $display("FAIL reset_conflict got %0d exp 0", conflict_cnt);
        end
`endif
        tick();
    endtask

    task automatic test_round_robin();
        logic [1:0]  exp_gnt [5];
        logic [4:0]  exp_rd  [5];
        logic [31:0] exp_dat [5];
        exp_gnt = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01};
        exp_rd  = '{5'd1, 5'd2, 5'd1, 5'd2, 5'd1};
        exp_dat = '{32'hA0A0_0000, 32'hB1B1_0001, 32'hA0A0_0000, 32'hB1B1_0001, 32'hA0A0_0000};
        req_rd    = {5'd2, 5'd1};
        req_data  = {32'hB1B1_0001, 32'hA0A0_0000};
        req_valid = 2'b11;
        for (int k = 0; k < 5; k++) begin
            // Requester 1 was served in the 4th cycle, so it may withdraw now.
            if (k == 4) req_valid = 2'b01;
            @(negedge clk);
            checks++;
            if (req_ready !== exp_gnt[k]) begin
                errors++; $display("FAIL rr_ready[%0d] got %b exp %b", k, req_ready, exp_gnt[k]);
            end
            tick();
            checks++;
            if (RegWrite !== 1'b1 || Rd !== exp_rd[k] || write_data !== exp_dat[k]) begin
                errors++;
                $display("FAIL rr_write[%0d] got we=%b rd=%0d d=%h exp we=1 rd=%0d d=%h",
                         k, RegWrite, Rd, write_data, exp_rd[k], exp_dat[k]);
            end
`ifdef RF_WB_STATS_EN
            if (k == 3) begin
                checks++;
                if (conflict_cnt !== 32'd4) begin
                    errors++; $display("FAIL rr_conflict got %0d exp 4", conflict_cnt);
                end
            end
`endif
        end
        req_valid = 2'b00;
        @(negedge clk);
        checks++;
        if (req_ready !== 2'b00) begin
            errors++; $display("FAIL rr_idle_ready got %b exp 00", req_ready);
        end
`ifdef RF_WB_STATS_EN
        checks++;
        if (conflict_cnt !== 32'd4) begin
            errors++; $display("FAIL rr_conflict_hold got %0d exp 4", conflict_cnt);
        end
`endif
        tick();
    endtask

    task automatic test_single();
        req_rd    = {5'd0, 5'd5};
        req_data  = {32'h0, 32'hDEAD_BEEF};
        req_valid = 2'b01;
        @(negedge clk);
        checks++;
        if (req_ready !== 2'b01) begin
            errors++; $display("FAIL single_ready got %b exp 01", req_ready);
        end
        tick();
        req_valid = 2'b00;
        checks++;
        if (RegWrite !== 1'b1 || Rd !== 5'd5 || write_data !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL single_write got we=%b rd=%0d d=%h exp we=1 rd=5 d=deadbeef", RegWrite, Rd, write_data);
        end
        tick();
        checks++;
        if (RegWrite !== 1'b0 || Rd !== 5'd5 || write_data !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL single_idle got we=%b rd=%0d d=%h exp we=0 rd=5 d=deadbeef", RegWrite, Rd, write_data);
        end
    endtask

    task automatic test_scoreboard();
        // rr_ptr is 1 here: requester 0 was granted last.
        alloc_valid = 1'b1;
        alloc_rd    = 5'd7;
        tick();
        alloc_valid = 1'b0;
        checks++;
        if (busy !== 32'h0000_0080) begin
            errors++; $display("FAIL sb_alloc7 got %h exp 00000080", busy);
        end
        tick();
        req_rd    = {5'd7, 5'd0};
        req_data  = {32'h7777_7777, 32'h0};
        req_valid = 2'b10;
        @(negedge clk);
        checks++;
        if (busy[7] !== 1'b1 || req_ready !== 2'b10) begin
            errors++; $display("FAIL sb_pre_wb got busy7=%b ready=%b exp 1/10", busy[7], req_ready);
        end
        tick();
        req_valid = 2'b00;
        checks++;
        if (busy !== 32'h0 || RegWrite !== 1'b1 || Rd !== 5'd7) begin
            errors++; $display("FAIL sb_clear7 got busy=%h we=%b rd=%0d exp 0/1/7", busy, RegWrite, Rd);
        end
        alloc_valid = 1'b1;
        alloc_rd    = 5'd9;
        tick();
        checks++;
        if (busy !== 32'h0000_0200) begin
            errors++; $display("FAIL sb_alloc9 got %h exp 00000200", busy);
        end
        // Same cycle: requester 0 retires r9 while r9 is re-allocated.
        req_rd    = {5'd0, 5'd9};
        req_data  = {32'h0, 32'h9999_0000};
        req_valid = 2'b01;
        tick();
        req_valid   = 2'b00;
        alloc_valid = 1'b0;
        checks++;
        if (busy !== 32'h0000_0200 || RegWrite !== 1'b1 || Rd !== 5'd9) begin
            errors++; $display("FAIL sb_set_wins got busy=%h we=%b rd=%0d exp 00000200/1/9", busy, RegWrite, Rd);
        end
        req_rd    = {5'd9, 5'd0};
        req_data  = {32'h9999_0001, 32'h0};
        req_valid = 2'b10;
        tick();
        req_valid = 2'b00;
        checks++;
        if (busy !== 32'h0 || write_data !== 32'h9999_0001) begin
            errors++; $display("FAIL sb_clear9 got busy=%h d=%h exp 0/99990001", busy, write_data);
        end
    endtask

    task automatic test_x0();
        req_rd    = {5'd0, 5'd0};
        req_data  = {32'h0, 32'h0000_1234};
        req_valid = 2'b01;
        @(negedge clk);
        checks++;
        if (req_ready !== 2'b01) begin
            errors++; $display("FAIL x0_ready got %b exp 01", req_ready);
        end
        tick();
        req_valid = 2'b00;
        checks++;
        if (RegWrite !== 1'b0 || busy[0] !== 1'b0) begin
            errors++; $display("FAIL x0_write got we=%b busy0=%b exp 0/0", RegWrite, busy[0]);
        end
        alloc_valid = 1'b1;
        alloc_rd    = 5'd0;
        tick();
        alloc_valid = 1'b0;
        checks++;
        if (busy !== 32'h0) begin
            errors++; $display("FAIL x0_alloc got %h exp 0", busy);
        end
    endtask

    task automatic test_async_reset();
        // rr_ptr is 1 after the x0 transfer by requester 0.
        alloc_valid = 1'b1;
        alloc_rd    = 5'd3;
        tick();
        alloc_valid = 1'b0;
        req_rd      = {5'd4, 5'd0};
        req_data    = {32'h0000_0055, 32'h0};
        req_valid   = 2'b10;
        tick();
        checks++;
        if (RegWrite !== 1'b1 || busy !== 32'h0000_0008) begin
            errors++; $display("FAIL ar_pre got we=%b busy=%h exp 1/00000008", RegWrite, busy);
        end
        req_rd    = {5'd8, 5'd6};
        req_data  = {32'h0000_0088, 32'h0000_0066};
        req_valid = 2'b11;
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (RegWrite !== 1'b0 || busy !== 32'h0 || Rd !== 5'd0 || write_data !== 32'h0) begin
            errors++;
            $display("FAIL ar_clear got we=%b busy=%h rd=%0d d=%h exp all 0", RegWrite, busy, Rd, write_data);
        end
        checks++;
        if (req_ready !== 2'b00) begin
            errors++; $display("FAIL ar_ready got %b exp 00", req_ready);
        end
        tick();
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (req_ready !== 2'b01) begin
            errors++; $display("FAIL ar_first_grant got %b exp 01", req_ready);
        end
        tick();
        checks++;
        if (RegWrite !== 1'b1 || Rd !== 5'd6 || write_data !== 32'h0000_0066) begin
            errors++; $display("FAIL ar_first_write got we=%b rd=%0d d=%h exp 1/6/66", RegWrite, Rd, write_data);
        end
        req_valid = 2'b10;
        @(negedge clk);
        checks++;
        if (req_ready !== 2'b10) begin
            errors++; $display("FAIL ar_second_grant got %b exp 10", req_ready);
        end
        tick();
        req_valid = 2'b00;
        checks++;
        if (RegWrite !== 1'b1 || Rd !== 5'd8 || write_data !== 32'h0000_0088) begin
            errors++; $display("FAIL ar_second_write got we=%b rd=%0d d=%h exp 1/8/88", RegWrite, Rd, write_data);
        end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_single();
        test_scoreboard();
        test_x0();
        test_async_reset();
        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
